// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared types and constants for the round-robin bus arbiter
package bus_arbiter_pkg;
  localparam int MAX_MASTERS = 8;
  localparam int ID_W = 3;
  typedef enum logic [1:0] {IDLE, GRANT, BUSY, RELEASE} state_e;
endpackage

// File: rtl/bus_arbiter_rr_priority_picker.sv
// rr_priority_picker: picks the first requester searching upward from last_i+1, wrapping at N
module rr_priority_picker
  import bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    req_i,
  input  logic [ID_W-1:0] last_i,
  output logic [N-1:0]    winner_o,
  output logic [ID_W-1:0] idx_o
);
  // Scan from farthest to nearest so the nearest requester after last_i overwrites the rest
  always_comb begin
    winner_o = '0;
    idx_o = '0;
    for (int k = N; k >= 1; k--)
      if (|(req_i & (N'(1) << ((int'(last_i) + k) % N)))) begin
        winner_o = N'(1) << ((int'(last_i) + k) % N);
        idx_o = ID_W'((int'(last_i) + k) % N);
      end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter holding the grant across a whole transaction, with a grant watchdog
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NR_OF_MASTERS = 4,
  parameter int GRANT_TIMEOUT = 15
) (
  input  logic                     clock_i,
  input  logic                     reset_ni,
  input  logic [NR_OF_MASTERS-1:0] request_bus_i,
  input  logic                     begin_transaction_i,
  input  logic                     end_transaction_i,
  input  logic                     bus_error_i,
  output logic [NR_OF_MASTERS-1:0] bus_grant_o,
  output logic [ID_W-1:0]          granted_id_o,
  output logic                     bus_idle_o,
  output logic                     timeout_pulse_o
);
  localparam int WD_W = $clog2(GRANT_TIMEOUT + 1);

  state_e                   state_q;
  logic [NR_OF_MASTERS-1:0] grant_q;
  logic [NR_OF_MASTERS-1:0] winner;
  logic [ID_W-1:0]          id_q;
  logic [ID_W-1:0]          last_q;
  logic [ID_W-1:0]          winner_idx;
  logic                     idle_q;
  logic                     timeout_q;
  logic [WD_W-1:0]          wd_q;
  logic [WD_W-1:0]          wd_d;

  rr_priority_picker #(.N(NR_OF_MASTERS)) u_picker (
    .req_i   (request_bus_i),
    .last_i  (last_q),
    .winner_o(winner),
    .idx_o   (winner_idx)
  );

  assign wd_d = (wd_q == '0) ? '0 : wd_q - 1'b1;

  // Arbitration state machine; grant, id, idle and timeout pulse are registered alongside the state
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      id_q      <= '0;
      last_q    <= ID_W'(NR_OF_MASTERS - 1);
      idle_q    <= 1'b1;
      timeout_q <= 1'b0;
      wd_q      <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE:
          if (|request_bus_i) begin
            grant_q <= winner;
            id_q    <= winner_idx;
            last_q  <= winner_idx;
            idle_q  <= 1'b0;
            wd_q    <= WD_W'(GRANT_TIMEOUT);
            state_q <= GRANT;
          end
        GRANT:
          if (begin_transaction_i) state_q <= BUSY;
          else if (bus_error_i || wd_q == '0) begin
            grant_q   <= '0;
            idle_q    <= 1'b1;
            timeout_q <= !bus_error_i;
            state_q   <= RELEASE;
          end else wd_q <= wd_d;
        BUSY:
          if (end_transaction_i || bus_error_i) begin
            grant_q <= '0;
            idle_q  <= 1'b1;
            state_q <= RELEASE;
          end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_grant_o     = grant_q;
  assign granted_id_o    = id_q;
  assign bus_idle_o      = idle_q;
  assign timeout_pulse_o = timeout_q;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the shared system bus. It sequences ownership among up to eight bus masters: the camera grabber, DMA engines and the CPU data port. Each master raises `requestBus` and receives a one-hot `busGrant`. The arbiter holds the grant across the master's whole transaction, from `beginTransaction` through `endTransaction` or bus error. A watchdog revokes a grant that is never used.

## Interface
- `nrOfMasters`, 4: number of requesters, legal range 2..8.
- `grantTimeout`, 15: cycles a granted master may take to assert `beginTransactionIn` before the grant is revoked, legal range 1..255.
- `clock`  in  1  system bus clock.
- `reset`  in  1  asynchronous, active-low reset.
- `requestBus`  in  nrOfMasters  per-master request, bit i = master i.
- `beginTransactionIn`  in  1  OR of all masters' beginTransaction.
- `endTransactionIn`  in  1  OR of all masters' endTransaction.
- `busErrorIn`  in  1  bus error from the slaves.
- `busGrant`  out  nrOfMasters  one-hot grant, registered.
- `grantedId`  out  3  index of the current or last grantee.
- `busIdle`  out  1  high when no grant is outstanding.
- `timeoutPulse`  out  1  one-cycle pulse when a grant is revoked by the watchdog.

## Operation
- Reset values:
  - `busGrant` = 0, `grantedId` = 0, `busIdle` = 1, `timeoutPulse` = 0.
  - State = IDLE; internal `lastGranted` = nrOfMasters-1, so master 0 has top priority first.
- IDLE:
  - If any `requestBus` bit is set, select the first requester searching upward from `lastGranted`+1, modulo nrOfMasters.
  - Assert that `busGrant` bit, load `grantedId` and `lastGranted`, load the watchdog with `grantTimeout`, go to GRANT.
- GRANT:
  - `beginTransactionIn` goes to BUSY.
  - `busErrorIn` goes to RELEASE.
  - Watchdog = 0 without begin goes to RELEASE and pulses `timeoutPulse`.
  - Otherwise decrement the watchdog.
  - Dropping `requestBus` does NOT release the grant. A master drops its request as soon as it sees the grant, before it begins its transaction.
- BUSY:
  - `endTransactionIn` or `busErrorIn` goes to RELEASE.
  - `requestBus` and `beginTransactionIn` are ignored.
- RELEASE:
  - `busGrant` is cleared and `busIdle` is set.
  - Always go to IDLE next cycle. This guarantees one dead cycle between owners.
- Requests outside IDLE are only sampled when the arbiter next returns to IDLE. There is no queueing beyond the live request level.
- Round-robin fairness: a master re-requesting immediately after its own transaction is served only after every other pending requester.

## Timing
- Request to grant: request sampled in IDLE at edge n; `busGrant` high after edge n+1.
- Grant release: end or error sampled at edge n; `busGrant` low after edge n+1 (state RELEASE).
- Next grant after release: the next grant can appear at the earliest 2 edges later (RELEASE then IDLE).
- Watchdog: a grant with no begin lasts exactly `grantTimeout`+1 cycles in GRANT.
- Simultaneous events:
  - Begin in the same cycle the watchdog hits 0: begin wins, no timeout.
  - End and error together: single RELEASE.
  - Error in GRANT: no `timeoutPulse`.
- Watchdog width: ceil(log2(grantTimeout+1)) bits, saturating at 0.
- Reset mid-transaction: all outputs return to reset values asynchronously; the state machine restarts in IDLE.

## Structure
- Shared package holds:
  - State encodings IDLE/GRANT/BUSY/RELEASE (2 bits).
  - Max-masters constant 8.
  - The grantedId width of 3.
- Sub-module `rr_priority_picker`: combinational. Inputs are the request vector and `lastGranted`; outputs are the one-hot winner and its index. It is instantiated once.
- State, watchdog, `lastGranted` and the output registers live in `bus_arbiter`.

## Test plan
- Reset release, master 2 requests -> `busGrant` = 0b0100 one cycle later; `grantedId` = 2; `busIdle` = 0.
- Masters 0,1,3 request continuously, each doing begin then end 4 cycles later -> grant order 0,1,3,0,1,3 with exactly one idle cycle between owners.
- Master 1 granted, drops request after 1 cycle, begins 2 cycles later -> grant held through end; no timeout.
- Master 0 granted, never begins, grantTimeout = 3 -> grant held 4 cycles; `timeoutPulse` for 1 cycle; `busIdle` = 1; next requester served.
- `busErrorIn` during BUSY -> grant drops the next cycle; `lastGranted` is updated so the erroring master is lowest priority.
- `reset` asserted low mid-BUSY -> `busGrant` = 0 immediately; after release, master 0 has priority again.
